// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: NCH channels of W bits, two-entry skid buffer,
// synchronous flush to a zero bubble, occupancy and saturating stall counter.
module pipe_stage_skid #(
  parameter int W   = 32'd32,
  parameter int NCH = 32'd4,
  parameter int CW  = 32'd16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*W-1:0]  in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*W-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [CW-1:0]     stall_cnt
);

  localparam int DW = NCH * W;

  logic          main_valid_r, skid_valid_r, in_ready_r;
  logic [DW-1:0] main_data_r, skid_data_r;
  logic [CW-1:0] stall_cnt_r;

  logic          main_valid_s, skid_valid_s, in_ready_s;
  logic [DW-1:0] main_data_s, skid_data_s;
  logic [CW-1:0] stall_cnt_s;
  logic          in_fire_s, out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;

  // Next-state for both entries, registered ready, and the stall counter.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    stall_cnt_s  = stall_cnt_r;

    if (flush) begin
      main_valid_s = 1'b0;
      main_data_s  = {DW{1'b0}};
      skid_valid_s = 1'b0;
      skid_data_s  = {DW{1'b0}};
    end else if (!main_valid_r || out_fire_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        if (in_fire_s) begin
          skid_valid_s = 1'b1;
          skid_data_s  = in_data;
        end else begin
          skid_valid_s = 1'b0;
          skid_data_s  = {DW{1'b0}};
        end
      end else if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
        main_data_s  = {DW{1'b0}};
      end
    end else begin
      if (in_fire_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = in_data;
      end else begin
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
      end
    end

    // Ready is computed from next state so it drops on the edge the skid fills.
    in_ready_s = !skid_valid_s;

    if (!flush && main_valid_r && !out_ready && (stall_cnt_r != {CW{1'b1}})) begin
      stall_cnt_s = stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DW{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DW{1'b0}};
      in_ready_r   <= 1'b1;
      stall_cnt_r  <= {CW{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= in_ready_s;
      stall_cnt_r  <= stall_cnt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed steps plus random traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int W   = 32;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int DW  = NCH * W;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Model: beats held by the stage, oldest first, plus stall count.
  logic [DW-1:0] mq[$];
  int            mstall = 0;

  pipe_stage_skid #(.W(W), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(mq.size() > 0));
    chk({tag, ".out_data"},  out_data, exp_data);
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(mq.size()));
    chk({tag, ".in_ready"},  DW'(in_ready), DW'(mq.size() < 2));
    chk({tag, ".stall_cnt"}, DW'(stall_cnt), DW'(mstall));
  endtask

  // Apply inputs at negedge, advance model at posedge, check just after.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f,
                       input logic r, input string tag);
    bit ofire, ifire, ovalid;
    @(negedge clk);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(posedge clk);
    ovalid = (mq.size() > 0);
    ofire  = ovalid && r;
    ifire  = v && (mq.size() < 2);
    if (f) begin
      mq.delete();
    end else begin
      if (ovalid && !r && mstall < CMAX) mstall++;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(d);
    end
    #1;
    check_model(tag);
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] x;
    x = '0;
    for (int k = 0; k < NCH; k++) x[k*W +: W] = W'(v);
    return x;
  endfunction

  initial begin
    logic [DW-1:0] d;
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat with per-channel bytes.
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    cycle(1'b1, d, 1'b0, 1'b1, "single");
    chk("single.data_const", out_data, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("single.occ_const", DW'(occupancy), DW'(1));
    cycle(1'b0, '0, 1'b0, 1'b1, "drain0");

    // Stream 1..8 back to back.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, rep(i), 1'b0, 1'b1, "stream");
      chk("stream.seq", out_data, rep(i));
    end
    cycle(1'b0, '0, 1'b0, 1'b1, "drain1");

    // Consumer stall with 1,2,3.
    cycle(1'b1, rep(1), 1'b0, 1'b0, "stall.a1");
    cycle(1'b1, rep(2), 1'b0, 1'b0, "stall.a2");
    chk("stall.ready_low", DW'(in_ready), DW'(0));
    cycle(1'b1, rep(3), 1'b0, 1'b0, "stall.hold3");
    chk("stall.cnt2", DW'(stall_cnt), DW'(2));
    cycle(1'b1, rep(3), 1'b0, 1'b1, "stall.r1");
    chk("stall.out2", out_data, rep(2));
    cycle(1'b1, rep(3), 1'b0, 1'b1, "stall.r2");
    chk("stall.out3", out_data, rep(3));
    cycle(1'b0, '0, 1'b0, 1'b1, "stall.r3");

    // Flush with the stage full, then flush of an accepted beat.
    cycle(1'b1, rep(8'hA1), 1'b0, 1'b0, "fl.fill1");
    cycle(1'b1, rep(8'hA2), 1'b0, 1'b0, "fl.fill2");
    cycle(1'b1, rep(8'hA3), 1'b1, 1'b0, "fl.full");
    chk("flush.occ0", DW'(occupancy), DW'(0));
    chk("flush.data0", out_data, '0);
    cycle(1'b1, rep(8'hB1), 1'b1, 1'b1, "fl.lost");
    cycle(1'b0, '0, 1'b0, 1'b1, "fl.after");
    chk("flush.nobeat", DW'(out_valid), DW'(0));

    // Stall counter saturation.
    cycle(1'b1, rep(8'hC1), 1'b0, 1'b0, "sat.load");
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, "sat");
    chk("sat.15", DW'(stall_cnt), DW'(15));
    cycle(1'b0, '0, 1'b0, 1'b1, "sat.drain");

    // Async reset mid-cycle with two beats held.
    cycle(1'b1, rep(8'hD1), 1'b0, 1'b0, "ar.fill1");
    cycle(1'b1, rep(8'hD2), 1'b0, 1'b0, "ar.fill2");
    chk("ar.occ2", DW'(occupancy), DW'(2));
    #2;
    rst_n = 1'b0;
    mq.delete();
    mstall = 0;
    #1;
    check_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
